n64_flashram: RTL

// - N64-facing FlashRAM save-chip emulator; the producer end of if_flashram.
// - Decodes 32-bit N64 commands and holds a 128-byte page buffer plus status.
// - Raises erase/program requests to the CPU, which performs them in SDRAM and acknowledges completion.
// - Sits between the N64 PI register decoder and cpu_flashram.

---
 rtl/flashram_pkg.sv | 14 +
 rtl/flashram_buffer.sv | 21 ++
 rtl/n64_flashram.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/flashram_pkg.sv
// flashram_pkg: opcodes, FSM states and status constants shared by the FlashRAM emulator.
package flashram_pkg;
    localparam logic [7:0] CMD_ERASE_SECTOR = 8'h4B;
    localparam logic [7:0] CMD_ERASE_CHIP   = 8'h3C;
    localparam logic [7:0] CMD_ERASE_START  = 8'h78;
    localparam logic [7:0] CMD_WRITE_BUF    = 8'hB4;
    localparam logic [7:0] CMD_PROGRAM      = 8'hA5;
    localparam logic [7:0] CMD_NOP          = 8'hD2;
    localparam logic [7:0] CMD_STATUS       = 8'hE1;
    localparam logic [7:0] CMD_READ         = 8'hF0;
    localparam logic [15:0] STATUS_ID = 16'h1111;
    localparam logic [11:0] STATUS_HI = 12'h800;
    typedef enum logic [2:0] {STATUS, READ, ERASE, WRITE_BUF, BUSY} e_state;
endpackage

// File: rtl/flashram_buffer.sv
// flashram_buffer: 32x32 page buffer with halfword write port, async CPU read and clear-fill port.
module flashram_buffer (
    input  logic        clk,
    input  logic        we_hi,
    input  logic        we_lo,
    input  logic [4:0]  waddr,
    input  logic [15:0] wdata,
    input  logic        fill_en,
    input  logic [4:0]  fill_addr,
    input  logic [4:0]  raddr,
    output logic [31:0] rdata
);
    logic [31:0] mem [32];
    assign rdata = mem[raddr];
    always_ff @(posedge clk)
        if (fill_en) mem[fill_addr] <= '1;
        else begin
            if (we_hi) mem[waddr][31:16] <= wdata;
            if (we_lo) mem[waddr][15:0] <= wdata;
        end
endmodule

// File: rtl/n64_flashram.sv
// n64_flashram: N64-side FlashRAM command decoder, page buffer and status for cpu_flashram.
// FLASHRAM_BUFFER_CLEAR_EN: fill the buffer with ones on entering WRITE_BUF, stalling N64 buffer writes.
module n64_flashram
    import flashram_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        n64_request,
    input  logic        n64_write,
    input  logic        n64_cmd_sel,
    input  logic [5:0]  n64_address,
    input  logic [15:0] n64_wdata,
    output logic [15:0] n64_rdata,
    output logic        n64_ack,
    output logic        read_mode,
    input  logic [4:0]  flashram_address,
    output logic [31:0] flashram_rdata,
    output logic [9:0]  flashram_sector,
    output logic        flashram_operation_pending,
    output logic        flashram_write_or_erase,
    output logic        flashram_sector_or_all,
    input  logic        flashram_operation_done
);
    e_state state, state_pd, state_n;
    logic [7:0] op;
    logic erase_done, write_done, commit, done_fire, act, buf_wr, stall, rel_wr, wr_en;
    logic filling, st;
    logic [4:0] fill_addr;
    logic [5:0] st_addr, w_addr;
    logic [15:0] st_data, w_data, rd_val;
    assign read_mode = state == READ;
    assign commit = n64_request & n64_write & n64_cmd_sel & n64_address[0];
    assign done_fire = flashram_operation_done & flashram_operation_pending;
    // completion lands before the commit is decoded, so BUSY may already have released
    assign state_pd = (done_fire && state == BUSY) ? STATUS : state;
    assign act = commit & (state_pd != BUSY || op == CMD_READ || op == CMD_STATUS);
    assign rd_val = (!n64_write && !n64_cmd_sel && (state == STATUS || state == BUSY)) ?
        (n64_address[0] ? {STATUS_HI, erase_done, write_done,
                           flashram_operation_pending & ~flashram_write_or_erase,
                           flashram_operation_pending & flashram_write_or_erase} : STATUS_ID) : 16'h0;
    assign buf_wr = n64_request & n64_write & ~n64_cmd_sel & (state == WRITE_BUF);
    assign stall = buf_wr & filling;
    assign rel_wr = st & ~filling;
    assign wr_en = (buf_wr & ~filling) | rel_wr;
    assign w_addr = st ? st_addr : n64_address;
    assign w_data = st ? st_data : n64_wdata;
    always_comb begin
        state_n = state_pd;
        if (act)
            case (op)
                CMD_ERASE_SECTOR, CMD_ERASE_CHIP: state_n = ERASE;
                CMD_ERASE_START: state_n = state_pd == ERASE ? BUSY : state_pd;
                CMD_WRITE_BUF: state_n = WRITE_BUF;
                CMD_PROGRAM: state_n = BUSY;
                CMD_STATUS: state_n = STATUS;
                CMD_READ: state_n = READ;
                CMD_NOP: state_n = state_pd;
                default: state_n = state_pd;
            endcase
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= STATUS;
            op <= '0;
            flashram_sector <= '0;
            flashram_operation_pending <= 1'b0;
            flashram_write_or_erase <= 1'b0;
            flashram_sector_or_all <= 1'b0;
            erase_done <= 1'b0;
            write_done <= 1'b0;
            n64_ack <= 1'b0;
            n64_rdata <= '0;
            st <= 1'b0;
            st_addr <= '0;
            st_data <= '0;
        end else begin
            state <= state_n;
            n64_ack <= (n64_request & ~stall) | rel_wr;
            n64_rdata <= n64_request ? rd_val : 16'h0;
            if (n64_request && n64_write && n64_cmd_sel && !n64_address[0]) op <= n64_wdata[15:8];
            if (done_fire) begin
                flashram_operation_pending <= 1'b0;
                if (flashram_write_or_erase) write_done <= 1'b1;
                else erase_done <= 1'b1;
            end
            if (act)
                case (op)
                    CMD_ERASE_SECTOR: begin
                        flashram_sector_or_all <= 1'b1;
                        flashram_write_or_erase <= 1'b0;
                        flashram_sector <= n64_wdata[9:0];
                    end
                    CMD_ERASE_CHIP: begin
                        flashram_sector_or_all <= 1'b0;
                        flashram_write_or_erase <= 1'b0;
                    end
                    CMD_ERASE_START:
                        if (state_pd == ERASE) begin
                            flashram_operation_pending <= 1'b1;
                            erase_done <= 1'b0;
                        end
                    CMD_PROGRAM: begin
                        flashram_sector <= n64_wdata[9:0];
                        flashram_write_or_erase <= 1'b1;
                        flashram_operation_pending <= 1'b1;
                        write_done <= 1'b0;
                    end
                    default: ;
                endcase
            if (stall) begin
                st <= 1'b1;
                st_addr <= n64_address;
                st_data <= n64_wdata;
            end else if (rel_wr) st <= 1'b0;
        end
`ifdef FLASHRAM_BUFFER_CLEAR_EN
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            filling <= 1'b0;
            fill_addr <= '0;
        end else if (act && op == CMD_WRITE_BUF) begin
            filling <= 1'b1;
            fill_addr <= '0;
        end else if (filling) begin
            filling <= state_n == WRITE_BUF && fill_addr != 5'd31;
            fill_addr <= fill_addr + 5'd1;
        end
`else
    assign filling = 1'b0;
    assign fill_addr = '0;
`endif
    flashram_buffer u_buf (
        .clk(clk),
        .we_hi(wr_en & ~w_addr[0]),
        .we_lo(wr_en & w_addr[0]),
        .waddr(w_addr[5:1]),
        .wdata(w_data),
        .fill_en(filling),
        .fill_addr(fill_addr),
        .raddr(flashram_address),
        .rdata(flashram_rdata)
    );
endmodule
